// File: rtl/mmio_mon_pkg.sv
// Shared types, default channel map and helpers for the MMIO settle monitor.
// Holds the per-channel FSM state type, the default LEDR/LEDG/HEX addresses,
// compare masks and golden patterns, plus a saturating-increment helper.
package mmio_mon_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_WAIT = 1'b1
  } ch_state_e;

  // Default peripheral word addresses
  localparam logic [31:0] ADDR_LEDR   = 32'h0000_7000;
  localparam logic [31:0] ADDR_LEDG   = 32'h0000_7010;
  localparam logic [31:0] ADDR_HEX_LO = 32'h0000_7020;
  localparam logic [31:0] ADDR_HEX_HI = 32'h0000_7024;

  // HEX digits are 7 bits each, packed with a zero pad bit per byte
  localparam logic [31:0] MASK_FULL   = 32'hFFFF_FFFF;
  localparam logic [31:0] MASK_HEX    = 32'h7F7F_7F7F;

  // Default golden patterns
  localparam logic [31:0] GOLDEN_LEDR   = 32'h0000_0001;
  localparam logic [31:0] GOLDEN_LEDG   = 32'h0000_0002;
  localparam logic [31:0] GOLDEN_HEX_LO = 32'h0804_0201;
  localparam logic [31:0] GOLDEN_HEX_HI = 32'h3F40_2010;

  // Increment v, holding at the all-ones value of a w-bit counter
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/mmio_settle_ch.sv
// One monitored channel: store capture, settle-latency FSM, saturating event
// counters and sticky golden-pattern flag. All outputs are registered.
// Ports: store bus snoop (we/addr/wdata), observed value, match/timeout pulses,
// last latency, match/timeout counts, golden flag, timeout-count-is-zero.
module mmio_settle_ch
  import mmio_mon_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MAX_LAT   = 4,
  parameter int                LAT_W     = 3,
  parameter int                CNT_W     = 16,
  parameter logic [ADDR_W-1:0] CH_ADDR   = ADDR_W'(ADDR_LEDR),
  parameter logic [DATA_W-1:0] CH_MASK   = DATA_W'(MASK_FULL),
  parameter logic [DATA_W-1:0] CH_GOLDEN = DATA_W'(GOLDEN_LEDR)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_lsu_we,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic [DATA_W-1:0] i_lsu_wdata,
  input  logic [DATA_W-1:0] i_obs,
  output logic              o_match,
  output logic              o_timeout,
  output logic [LAT_W-1:0]  o_latency,
  output logic              o_golden_seen,
  output logic [CNT_W-1:0]  o_match_cnt,
  output logic [CNT_W-1:0]  o_timeout_cnt,
  output logic              o_tcnt_zero
);

  ch_state_e         state_q, state_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              match_d, timeout_d, golden_d;
  logic [LAT_W-1:0]  latency_d;
  logic [CNT_W-1:0]  mcnt_d, tcnt_d;

  logic              hit, eq, eq_golden;
  logic [LAT_W-1:0]  lat_inc;

  assign hit       = i_en && i_lsu_we && (i_lsu_addr == CH_ADDR);
  assign eq        = ((i_obs ^ exp_q) & CH_MASK) == '0;
  assign eq_golden = ((i_obs ^ CH_GOLDEN) & CH_MASK) == '0;
  // lat_q counts completed compares; lat_inc is the latency if this one matches
  assign lat_inc   = lat_q + LAT_W'(1);

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    lat_d     = lat_q;
    match_d   = 1'b0;
    timeout_d = 1'b0;
    latency_d = o_latency;
    mcnt_d    = o_match_cnt;
    tcnt_d    = o_timeout_cnt;
    golden_d  = o_golden_seen | (i_en & eq_golden);

    case (state_q)
      CH_IDLE: begin
        if (hit) begin
          state_d = CH_WAIT;
          exp_d   = i_lsu_wdata;
          lat_d   = '0;
        end
      end
      CH_WAIT: begin
        if (hit) begin
          // A newer store supersedes the pending one silently
          exp_d = i_lsu_wdata;
          lat_d = '0;
        end else begin
          lat_d = lat_inc;
          if (eq) begin
            match_d   = 1'b1;
            latency_d = lat_inc;
            mcnt_d    = CNT_W'(sat_inc(32'(o_match_cnt), CNT_W));
            state_d   = CH_IDLE;
          end else if (lat_inc == LAT_W'(MAX_LAT)) begin
            timeout_d = 1'b1;
            tcnt_d    = CNT_W'(sat_inc(32'(o_timeout_cnt), CNT_W));
            state_d   = CH_IDLE;
          end
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= CH_IDLE;
      exp_q         <= '0;
      lat_q         <= '0;
      o_match       <= 1'b0;
      o_timeout     <= 1'b0;
      o_latency     <= '0;
      o_match_cnt   <= '0;
      o_timeout_cnt <= '0;
      o_golden_seen <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      lat_q         <= lat_d;
      o_match       <= match_d;
      o_timeout     <= timeout_d;
      o_latency     <= latency_d;
      o_match_cnt   <= mcnt_d;
      o_timeout_cnt <= tcnt_d;
      o_golden_seen <= golden_d;
    end
  end

  assign o_tcnt_zero = (o_timeout_cnt == '0);

endmodule

// File: rtl/mmio_settle_monitor.sv
// Write-to-output settle monitor for N_CH memory-mapped output peripherals.
// Ports: LSU store snoop, insn-valid, packed observed outputs (channel 0 in LSBs);
// per-channel match/timeout pulses, latency, counts, golden flags, vld_seen, all_pass.
module mmio_settle_monitor
  import mmio_mon_pkg::*;
#(
  parameter int                       N_CH      = 4,
  parameter int                       ADDR_W    = 32,
  parameter int                       DATA_W    = 32,
  parameter int                       MAX_LAT   = 4,
  parameter int                       LAT_W     = 3,
  parameter int                       CNT_W     = 16,
  parameter logic [N_CH*ADDR_W-1:0]   CH_ADDR   = {ADDR_HEX_HI, ADDR_HEX_LO, ADDR_LEDG, ADDR_LEDR},
  parameter logic [N_CH*DATA_W-1:0]   CH_MASK   = {MASK_HEX, MASK_HEX, MASK_FULL, MASK_FULL},
  parameter logic [N_CH*DATA_W-1:0]   CH_GOLDEN = {GOLDEN_HEX_HI, GOLDEN_HEX_LO, GOLDEN_LEDG, GOLDEN_LEDR}
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_lsu_we,
  input  logic [ADDR_W-1:0]      i_lsu_addr,
  input  logic [DATA_W-1:0]      i_lsu_wdata,
  input  logic                   i_insn_vld,
  input  logic [N_CH*DATA_W-1:0] i_obs,
  output logic [N_CH-1:0]        o_match,
  output logic [N_CH-1:0]        o_timeout,
  output logic [N_CH*LAT_W-1:0]  o_latency,
  output logic [N_CH-1:0]        o_golden_seen,
  output logic [N_CH*CNT_W-1:0]  o_match_cnt,
  output logic [N_CH*CNT_W-1:0]  o_timeout_cnt,
  output logic                   o_vld_seen,
  output logic                   o_all_pass
);

  logic [N_CH-1:0] tcnt_zero;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    mmio_settle_ch #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MAX_LAT   (MAX_LAT),
      .LAT_W     (LAT_W),
      .CNT_W     (CNT_W),
      .CH_ADDR   (CH_ADDR[c*ADDR_W +: ADDR_W]),
      .CH_MASK   (CH_MASK[c*DATA_W +: DATA_W]),
      .CH_GOLDEN (CH_GOLDEN[c*DATA_W +: DATA_W])
    ) u_ch (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_en          (i_en),
      .i_lsu_we      (i_lsu_we),
      .i_lsu_addr    (i_lsu_addr),
      .i_lsu_wdata   (i_lsu_wdata),
      .i_obs         (i_obs[c*DATA_W +: DATA_W]),
      .o_match       (o_match[c]),
      .o_timeout     (o_timeout[c]),
      .o_latency     (o_latency[c*LAT_W +: LAT_W]),
      .o_golden_seen (o_golden_seen[c]),
      .o_match_cnt   (o_match_cnt[c*CNT_W +: CNT_W]),
      .o_timeout_cnt (o_timeout_cnt[c*CNT_W +: CNT_W]),
      .o_tcnt_zero   (tcnt_zero[c])
    );
  end

  // all_pass is built from registered flags, so it trails them by one cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vld_seen <= 1'b0;
      o_all_pass <= 1'b0;
    end else begin
      o_vld_seen <= o_vld_seen | (i_en & i_insn_vld);
      o_all_pass <= o_vld_seen && (&o_golden_seen) && (&tcnt_zero);
    end
  end

endmodule

// File: tb/tb_mmio_settle_monitor.sv
module tb_mmio_settle_monitor;

  localparam int NC = 4;
  localparam int LW = 3;
  localparam int CW = 4;
  localparam int ML = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          we = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic          insn_vld = 1'b0;
  logic [127:0]  obs = '0;

  logic [NC-1:0]    d_match, d_timeout, d_golden;
  logic [NC*LW-1:0] d_lat;
  logic [NC*CW-1:0] d_mcnt, d_tcnt;
  logic             d_vld, d_allp;

  mmio_settle_monitor #(.CNT_W(CW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_lsu_we      (we),
    .i_lsu_addr    (addr),
    .i_lsu_wdata   (wdata),
    .i_insn_vld    (insn_vld),
    .i_obs         (obs),
    .o_match       (d_match),
    .o_timeout     (d_timeout),
    .o_latency     (d_lat),
    .o_golden_seen (d_golden),
    .o_match_cnt   (d_mcnt),
    .o_timeout_cnt (d_tcnt),
    .o_vld_seen    (d_vld),
    .o_all_pass    (d_allp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_addr [NC] = '{32'h7000, 32'h7010, 32'h7020, 32'h7024};
  logic [31:0] m_mask [NC] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7F7F7F7F, 32'h7F7F7F7F};
  logic [31:0] m_gpat [NC] = '{32'h00000001, 32'h00000002, 32'h08040201, 32'h3F402010};

  bit          pend   [NC];   // store outstanding
  logic [31:0] want   [NC];   // value the store expects to appear
  int          waited [NC];   // cycles elapsed since the store was taken
  bit          e_match[NC], e_to[NC], e_gold[NC];
  int          e_lat  [NC], e_mcnt[NC], e_tcnt[NC];
  bit          e_vld, e_allp;

  always @(posedge clk) begin
    bit nxt_allp;
    nxt_allp = e_vld;
    for (int c = 0; c < NC; c++) nxt_allp = nxt_allp && e_gold[c] && (e_tcnt[c] == 0);
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        pend[c] = 0; want[c] = '0; waited[c] = 0;
        e_match[c] = 0; e_to[c] = 0; e_gold[c] = 0;
        e_lat[c] = 0; e_mcnt[c] = 0; e_tcnt[c] = 0;
      end
      e_vld = 0; e_allp = 0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        logic [31:0] o;
        o = obs[c*32 +: 32];
        e_match[c] = 0; e_to[c] = 0;
        if (en && we && addr == m_addr[c]) begin
          pend[c] = 1; want[c] = wdata; waited[c] = 0;
        end else if (pend[c]) begin
          waited[c] = waited[c] + 1;
          if (((o ^ want[c]) & m_mask[c]) == 0) begin
            e_match[c] = 1; e_lat[c] = waited[c]; pend[c] = 0;
            if (e_mcnt[c] < CMAX) e_mcnt[c] = e_mcnt[c] + 1;
          end else if (waited[c] >= ML) begin
            e_to[c] = 1; pend[c] = 0;
            if (e_tcnt[c] < CMAX) e_tcnt[c] = e_tcnt[c] + 1;
          end
        end
        if (en && (((o ^ m_gpat[c]) & m_mask[c]) == 0)) e_gold[c] = 1;
      end
      if (en && insn_vld) e_vld = 1;
      e_allp = nxt_allp;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [NC-1:0]    xm, xt, xg;
    logic [NC*LW-1:0] xl;
    logic [NC*CW-1:0] xmc, xtc;
    if (chk_on) begin
      for (int c = 0; c < NC; c++) begin
        xm[c] = e_match[c]; xt[c] = e_to[c]; xg[c] = e_gold[c];
        xl[c*LW +: LW]  = LW'(e_lat[c]);
        xmc[c*CW +: CW] = CW'(e_mcnt[c]);
        xtc[c*CW +: CW] = CW'(e_tcnt[c]);
      end
      check("model_match",   d_match,   xm);
      check("model_timeout", d_timeout, xt);
      check("model_latency", d_lat,     xl);
      check("model_golden",  d_golden,  xg);
      check("model_mcnt",    d_mcnt,    xmc);
      check("model_tcnt",    d_tcnt,    xtc);
      check("model_vld",     d_vld,     e_vld);
      check("model_allpass", d_allp,    e_allp);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cyc(); cyc();
    chk_on = 1'b1;
    check("rst_match",   d_match,  0);
    check("rst_mcnt",    d_mcnt,   0);
    check("rst_tcnt",    d_tcnt,   0);
    check("rst_golden",  d_golden, 0);
    check("rst_allpass", d_allp,   0);
    rst = 1'b0; en = 1'b1;

    // 1: LEDR store, output follows two cycles later
    store(32'h7000, 32'h1); cyc();
    we = 1'b0; cyc();
    obs[31:0] = 32'h1; cyc();
    check("t1_match",   d_match[0],   1);
    check("t1_latency", d_lat[2:0],   2);
    check("t1_mcnt",    d_mcnt[3:0],  1);
    check("t1_golden",  d_golden[0],  1);
    cyc();
    check("t1_single",  d_match[0],   0);

    // 2: LEDG store never appears
    store(32'h7010, 32'hDEADBEEF); cyc();
    we = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("t2_timeout_at", d_timeout[1], (k == 4) ? 1 : 0);
    end
    check("t2_tcnt",    d_tcnt[7:4], 1);
    check("t2_allpass", d_allp,      0);

    // 3: HEX lo with bit 31 masked off
    store(32'h7020, 32'h88040201); cyc();
    we = 1'b0; obs[95:64] = 32'h08040201; cyc();
    check("t3_match",   d_match[2],  1);
    check("t3_latency", d_lat[8:6],  1);
    check("t3_golden",  d_golden[2], 1);

    // 4: back-to-back stores, second supersedes first (hit beats match)
    store(32'h7000, 32'h11); cyc();
    store(32'h7000, 32'h22); obs[31:0] = 32'h11; cyc();
    check("t4_no_pulse_rearm", d_match[0], 0);
    we = 1'b0; cyc();
    check("t4_no_pulse_wait", d_match[0], 0);
    obs[31:0] = 32'h22; cyc();
    check("t4_match",   d_match[0],  1);
    check("t4_latency", d_lat[2:0],  2);
    check("t4_mcnt",    d_mcnt[3:0], 2);
    cyc();
    check("t4_no_timeout", d_timeout[0], 0);

    // enable low blocks arming; falling enable lets a window finish
    en = 1'b0; store(32'h7000, 32'h55); cyc();
    we = 1'b0; obs[31:0] = 32'h55; cyc(); cyc();
    check("en_blocked", d_mcnt[3:0], 2);
    en = 1'b1; store(32'h7000, 32'h77); cyc();
    en = 1'b0; we = 1'b0; obs[31:0] = 32'h77; cyc();
    check("en_fall_match", d_match[0], 1);
    check("en_fall_mcnt",  d_mcnt[3:0], 3);
    en = 1'b1;

    // all goldens + vld but a timeout already recorded
    obs[63:32] = 32'h2; obs[127:96] = 32'h3F402010; insn_vld = 1'b1; cyc();
    insn_vld = 1'b0; cyc();
    check("g_all",       d_golden, 4'hF);
    check("g_vld",       d_vld,    1);
    check("g_allpass_0", d_allp,   0);

    // 5: reset while channel 3 waits
    obs[127:96] = 32'h0; store(32'h7024, 32'h12345678); cyc();
    rst = 1'b1; we = 1'b0; obs[127:96] = 32'h12345678; cyc();
    check("t5_match",  d_match,  0);
    check("t5_mcnt",   d_mcnt,   0);
    check("t5_tcnt",   d_tcnt,   0);
    check("t5_golden", d_golden, 0);
    check("t5_vld",    d_vld,    0);
    rst = 1'b0; cyc();
    check("t5_aborted", d_match[3], 0);

    // 6a: all_pass rises one cycle after the last golden flag
    obs[31:0] = 32'h1; obs[63:32] = 32'h2; obs[95:64] = 32'h08040201;
    obs[127:96] = 32'h0; insn_vld = 1'b1; cyc();
    insn_vld = 1'b0;
    check("t6_golden_part", d_golden, 4'b0111);
    obs[127:96] = 32'h3F402010; cyc();
    check("t6_golden_all",  d_golden, 4'hF);
    check("t6_allpass_lag", d_allp,   0);
    cyc();
    check("t6_allpass",     d_allp,   1);

    // 6b: saturate channel 1 timeout counter
    for (int n = 0; n < CMAX + 2; n++) begin
      store(32'h7010, 32'hDEADBEEF); cyc();
      we = 1'b0;
      for (int k = 0; k < ML; k++) cyc();
    end
    check("t6_sat",         d_tcnt[7:4], 4'hF);
    check("t6_allpass_off", d_allp,      0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_settle_monitor.md
Name: mmio_settle_monitor

Overview:
Synthesizable, parametrised monitor for write-to-output settle latency on memory-mapped output peripherals. It replaces ad-hoc fork/wait checks in the core benches with a reusable clocked block. The block snoops the LSU store bus and tracks N_CH output channels (LEDR, LEDG, HEX lo/hi by default). For each channel it measures cycles from store to visible output, flags stores that do not settle in time, and latches a sticky "golden pattern seen" flag. It is instantiated beside the singlecycle core in benches, or on FPGA with outputs routed to debug LEDs.

Parameters:
N_CH, 4, number of monitored channels; channel 0 occupies the LSBs of all packed vectors
ADDR_W, 32, LSU address width
DATA_W, 32, LSU data / channel observation width
MAX_LAT, 4, settle window in cycles; must be ≥1
LAT_W, 3, latency field width; must satisfy 2^LAT_W > MAX_LAT
CNT_W, 16, width of each saturating event counter
CH_ADDR, {32'h7024,32'h7020,32'h7010,32'h7000}, per-channel word address, N_CH*ADDR_W
CH_MASK, {32'h7F7F7F7F,32'h7F7F7F7F,32'hFFFFFFFF,32'hFFFFFFFF}, compare mask per channel
CH_GOLDEN, {32'h3F402010,32'h08040201,32'h00000002,32'h00000001}, expected pattern per channel

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_en  in  1  monitoring enable; when 0, arming and golden detection are suppressed
i_lsu_we  in  1  LSU store strobe
i_lsu_addr  in  ADDR_W  LSU address
i_lsu_wdata  in  DATA_W  LSU store data
i_insn_vld  in  1  core instruction-valid
i_obs  in  N_CH*DATA_W  observed channel outputs (HEX packed as {1'b0,hex3,1'b0,hex2,...})
o_match  out  N_CH  1-cycle pulse: channel settled within the window
o_timeout  out  N_CH  1-cycle pulse: settle window expired without a match
o_latency  out  N_CH*LAT_W  per-channel latency of the last match
o_golden_seen  out  N_CH  sticky flag: masked golden pattern observed
o_match_cnt  out  N_CH*CNT_W  saturating count of matches
o_timeout_cnt  out  N_CH*CNT_W  saturating count of timeouts
o_vld_seen  out  1  sticky flag: i_insn_vld has been observed high
o_all_pass  out  1  registered pass: o_vld_seen && &o_golden_seen && all timeout counts 0

Behaviour:
- Reset (i_rst=1 at an edge): every output and counter is 0; all channels go to IDLE. Reset applied mid-operation aborts any WAIT with no pulse.
- Address hit for channel c: i_en && i_lsu_we && i_lsu_addr==CH_ADDR[c]. Full-address compare; no byte lanes.
- Masked compare: eq[c] = ((i_obs[c] ^ exp[c]) & CH_MASK[c]) == 0.
- Per-channel FSM has states IDLE and WAIT.
  - IDLE, on hit: capture exp ← wdata, set lat ← 0, go to WAIT.
  - WAIT, each cycle: lat ← lat+1.
    - If eq: pulse o_match, set o_latency ← lat+1, increment match_cnt, go to IDLE.
    - Else if lat+1 == MAX_LAT: pulse o_timeout, increment timeout_cnt, go to IDLE.
  - The first compare happens the cycle after the store, so a one-cycle registered peripheral reports latency 1.
- Hit while in WAIT: re-arm. Capture the new data, set lat ← 0, stay in WAIT, emit no pulse for the superseded store. The hit takes priority over match/timeout in the same cycle.
- i_en falling while in WAIT: finish the current window normally; only new arming is blocked.
- Counters saturate at 2^CNT_W−1 and never wrap.
- o_golden_seen[c] sets when i_en && eq_golden[c], where eq_golden[c] is the masked compare of i_obs[c] against CH_GOLDEN[c]. It is independent of the FSM and clears only on reset.
- o_vld_seen sets on i_en && i_insn_vld.
- o_all_pass is registered, so it lags its inputs by one cycle.
- Pulses and counters are registered, so all effects appear one cycle after the causing compare.

Decomposition:
- Package mmio_mon_pkg holds:
  - typedef ch_state_e {CH_IDLE, CH_WAIT};
  - the default address, mask and golden constants (ADDR_LEDR, ADDR_LEDG, ADDR_HEX_LO, ADDR_HEX_HI, MASK_HEX);
  - a saturating-increment function.
- Sub-module mmio_settle_ch implements one channel (FSM, latency, counters, golden flag). The top generates N_CH instances and reduces the per-channel results for o_all_pass.

Test Plan:
1. Store 0x00000001 to 0x7000; i_obs[0] becomes 0x00000001 two cycles later → o_match[0] pulses once, o_latency[0]=2, match_cnt[0]=1, golden_seen[0]=1.
2. Store 0xDEADBEEF to 0x7010 with i_obs[1] held at 0 → o_timeout[1] pulses exactly 4 cycles after the store, timeout_cnt[1]=1, o_all_pass stays 0.
3. Store 0x88040201 to 0x7020; i_obs[2]=0x08040201 next cycle (bit 31 masked) → match with latency 1, golden_seen[2]=1.
4. Store 0x11 to 0x7000, then store 0x22 one cycle later; i_obs[0]=0x22 at +2 → exactly one match pulse, latency 2 relative to the second store, no timeout.
5. Assert i_rst while channel 3 is in WAIT → no pulses; all counters and flags read 0 on the next cycle.
6. All four golden patterns seen plus one i_insn_vld, with no timeouts → o_all_pass=1 one cycle after the last flag sets; 2^CNT_W forced timeouts on one channel → count holds at max.
